// File: rtl/btn_press_decoder.sv
// btn_press_decoder: turns the debounced button level into press, release,
// long-press and auto-repeat pulses, a held level and a wrapping press count.
//   clk, rst      : clock and synchronous active-high reset
//   btn           : debounced, clk-synchronous button level
//   press         : 1-cycle pulse on an accepted rising edge
//   release_pulse : 1-cycle pulse on the falling edge after a press
//   long_press    : 1-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  : 1-cycle pulse every REPEAT_CYCLES after long_press
//   held          : high while the press is active
//   press_count   : accepted presses modulo 2^CNT_W
// "release" and "repeat" are reserved words, hence the _pulse suffix.
module btn_press_decoder #(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  output logic             press,
  output logic             release_pulse,
  output logic             long_press,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned MAX_C = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  state_t           state, state_n;
  logic [HW-1:0]    cnt, cnt_n;
  logic             armed, armed_n;
  logic             press_n, release_n, long_n, repeat_n, held_n;
  logic [CNT_W-1:0] count_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      armed         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      armed         <= armed_n;
      press         <= press_n;
      release_pulse <= release_n;
      long_press    <= long_n;
      repeat_pulse  <= repeat_n;
      held          <= held_n;
      press_count   <= count_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    armed_n   = armed | ~btn;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    held_n    = held;
    count_n   = press_count;
    case (state)
      IDLE: begin
        if (btn && armed) begin
          state_n = HOLD;
          press_n = 1'b1;
          held_n  = 1'b1;
          cnt_n   = '0;
          count_n = press_count + 1'b1;
        end
      end
      HOLD, RPT: begin
        // Release is tested first so a low sample at the threshold edge
        // suppresses long_press/repeat.
        if (!btn) begin
          state_n   = IDLE;
          release_n = 1'b1;
          held_n    = 1'b0;
          cnt_n     = '0;
        end else if (state == HOLD && cnt == LONG_LAST) begin
          state_n = RPT;
          long_n  = 1'b1;
          cnt_n   = '0;
        end else if (state == RPT && cnt == REPEAT_LAST) begin
          repeat_n = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_btn_press_decoder.sv
module tb_btn_press_decoder;
  localparam int unsigned L  = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn;
  logic          press, release_pulse, long_press, repeat_pulse, held;
  logic [CW-1:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  btn_press_decoder #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks how many edges the button has been held since the press
  // edge and derives events arithmetically from that hold length.
  bit m_started = 0, m_armed = 0, m_pressed = 0;
  bit m_press = 0, m_rel = 0, m_long = 0, m_rpt = 0;
  int m_k = 0, m_count = 0;

  initial begin
    forever begin
      @(posedge clk);
      m_press = 0; m_rel = 0; m_long = 0; m_rpt = 0;
      if (rst) begin
        m_started = 1; m_armed = 0; m_pressed = 0; m_k = 0; m_count = 0;
      end else begin
        if (!m_pressed) begin
          if (btn && m_armed) begin
            m_press = 1; m_pressed = 1; m_k = 0;
            m_count = (m_count + 1) % (1 << CW);
          end
        end else if (!btn) begin
          m_rel = 1; m_pressed = 0;
        end else begin
          m_k++;
          if (m_k == L) m_long = 1;
          else if (m_k > L && (m_k - L) % R == 0) m_rpt = 1;
        end
        if (!btn) m_armed = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        check("press", press, m_press);
        check("release", release_pulse, m_rel);
        check("long_press", long_press, m_long);
        check("repeat", repeat_pulse, m_rpt);
        check("held", held, m_pressed);
        check("press_count", press_count, m_count);
        check("exclusive", (press + release_pulse + long_press + repeat_pulse) <= 1, 1);
      end
    end
  end

  task automatic step(input logic b, input logic r);
    btn = b;
    rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  int held_cycles;

  initial begin
    btn = 1'b0;
    rst = 1'b1;
    step(0, 1);
    check("reset_press", press, 0);
    check("reset_held", held, 0);
    check("reset_count", press_count, 0);

    // Short tap
    repeat (3) step(0, 0);
    held_cycles = 0;
    step(1, 0);
    check("tap_press", press, 1);
    held_cycles += int'(held);
    step(1, 0);
    check("tap_press_once", press, 0);
    held_cycles += int'(held);
    step(1, 0);
    held_cycles += int'(held);
    step(0, 0);
    check("tap_release", release_pulse, 1);
    check("tap_held_low", held, 0);
    held_cycles += int'(held);
    check("tap_held_cycles", held_cycles, 3);
    check("tap_count", press_count, 1);
    step(0, 0);

    // Long hold: high at edges t..t+20
    step(1, 0);
    check("long_press_edge", press, 1);
    for (int i = 1; i <= 20; i++) begin
      step(1, 0);
      if (i == 7)  check("long_early", long_press, 0);
      if (i == 8)  check("long_fire", long_press, 1);
      if (i == 12) check("repeat_12", repeat_pulse, 1);
      if (i == 15) check("repeat_15", repeat_pulse, 0);
      if (i == 16) check("repeat_16", repeat_pulse, 1);
      if (i == 20) check("repeat_20", repeat_pulse, 1);
    end
    step(0, 0);
    check("long_release", release_pulse, 1);
    check("long_count", press_count, 2);

    // Threshold collision
    step(1, 0);
    for (int i = 1; i <= 7; i++) step(1, 0);
    step(0, 0);
    check("thr_release", release_pulse, 1);
    check("thr_no_long", long_press, 0);

    // Reset mid-hold
    repeat (5) step(1, 0);
    step(1, 1);
    check("mid_rst_held", held, 0);
    check("mid_rst_count", press_count, 0);
    check("mid_rst_release", release_pulse, 0);
    repeat (3) begin
      step(1, 0);
      check("mid_rst_no_press", press, 0);
    end
    step(0, 0);
    step(1, 0);
    check("mid_rst_repress", press, 1);
    check("mid_rst_count1", press_count, 1);
    step(0, 0);

    // Counter wrap
    step(0, 1);
    step(0, 0);
    for (int n = 1; n <= 17; n++) begin
      step(1, 0);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      if (n == 15) check("wrap_15", press_count, 15);
      if (n == 16) check("wrap_0", press_count, 0);
      if (n == 17) check("wrap_1", press_count, 1);
    end

    // Back-to-back
    step(1, 0);
    check("b2b_press1", press, 1);
    step(0, 0);
    check("b2b_release", release_pulse, 1);
    step(1, 0);
    check("b2b_press2", press, 1);
    check("b2b_count", press_count, 3);
    step(0, 0);
    step(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_press_decoder.md
# btn_press_decoder

Converts the clean, single-clock level from the debouncer into discrete user events: a one-cycle press pulse, a one-cycle release pulse, a long-press pulse, and auto-repeat pulses while the button stays held. It also keeps a wrapping press counter. It sits directly downstream of the debouncer and feeds the control logic that steps parameters (interval bounds, step count) of the Simpson's-rule integrator.

## Interface
- LONG_CYCLES, 25_000_000: cycles the button must stay held after the press edge before long_press fires (≥2).
- REPEAT_CYCLES, 5_000_000: period of repeat pulses after long_press (≥1).
- CNT_W, 8: width of the press counter.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  1  debounced button level (debouncer `out`), already synchronous to clk.
- press  output  1  one-cycle pulse on an accepted rising edge.
- release  output  1  one-cycle pulse on a falling edge after an accepted press.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat  output  1  one-cycle pulse every REPEAT_CYCLES after long_press while held.
- held  output  1  level, high from the press pulse through the cycle before the release pulse.
- press_count  output  CNT_W  number of accepted presses, modulo 2^CNT_W.

## Operation
- All outputs are registered. Reset values: press, release, long_press and repeat are 0; held is 0; press_count is 0; state is IDLE; the internal `armed` flag is 0.
- Arming:
  - `armed` sets on any edge where btn is sampled 0.
  - A button held through reset produces no press until it has been seen low once.
- State machine:
  - IDLE: on `btn=1 && armed`, go to HOLD, assert press, set held=1, clear hold counter to 0, and increment press_count.
  - HOLD: the counter increments each edge while btn=1. When it reaches LONG_CYCLES-1, assert long_press, go to REPEAT, and clear the counter.
  - REPEAT: the counter increments each edge while btn=1. When it reaches REPEAT_CYCLES-1, assert repeat and clear the counter.
  - HOLD or REPEAT with btn=0: assert release, set held=0, go to IDLE, and clear the counter.
- Priority on the same edge: release beats long_press and repeat. A sample of btn=0 at the threshold edge yields release only.
- Counter width is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)). The counter saturates at no value other than its threshold and never wraps while held.
- press_count wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-hold:
  - Reset forces the reset values.
  - No release pulse is generated.
  - Because `armed` is 0, a still-held button yields no press after reset deasserts.
- Pulses are mutually exclusive in any cycle.

## Timing
- Let edge t be the first edge that samples btn=1 with armed=1.
  - press=1 and held=1 during cycle t..t+1, i.e. visible right after edge t.
  - Latency from btn sampled to press visible is one edge.
- long_press is high after edge t+LONG_CYCLES, provided btn was sampled 1 at edges t..t+LONG_CYCLES.
- repeat is high after edge t+LONG_CYCLES+k·REPEAT_CYCLES, for k=1,2,…, while btn stays 1.
- If the first edge sampling btn=0 is edge r, then release=1 after edge r and held=0 after edge r.
- A new press is possible at edge r+1 at the earliest: back-to-back presses need btn low for ≥1 edge.
- Minimum press-to-release spacing is one cycle. A one-sample-high btn gives press after t and release after t+1.

## Test plan
Run with LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4 and a 4 ns clk.
- Short tap: btn low for 3 edges, high for 3 edges, then low → press 1 cycle after the first high sample; release 1 cycle after the first low sample; held high exactly 3 cycles; press_count=1; no long_press.
- Long hold: btn high for 20 edges from edge t → long_press after t+8; repeat after t+12, t+16 and t+20; release after the first low sample; press, long_press, repeat and release are never high in the same cycle.
- Threshold collision: btn high at edges t..t+7 and low at t+8 → release after t+8; no long_press.
- Reset mid-hold: hold 5 edges, pulse rst 1 cycle with btn still high → all outputs 0, press_count=0; no press while btn stays high; a press pulse follows the next low→high.
- Counter wrap: 17 taps, each high 2 edges and low 2 edges → press_count reaches 15, then 0, then 1.
- Back-to-back: btn 1,0,1 on consecutive edges from an armed idle state → two press pulses, one release between them; press_count increments by 2.
